// File: rtl/store_watch_monitor.sv
// store_watch_monitor: programmable store-watch channels plus forwarding
// statistics; decides test pass/fail in hardware from snooped core stores.
// Ports:
//   clk, reset        : clock and sync active-high reset
//   cfg_*             : channel config write (ignored while armed)
//   start_i           : arm monitor
//   memwrite_i, dataadr_i, writedata_i : snooped store port
//   forwardae_i, forwardbe_i           : hazard-unit forward selects
//   armed_o, pass_o, fail_o            : monitor state
//   hit_vec_o         : per-channel done
//   cycle_cnt_o, store_cnt_o, fwd_a_cnt_o, fwd_b_cnt_o : statistics
module store_watch_monitor #(
  parameter int XLEN           = 32,
  parameter int NUM_WATCH      = 2,
  parameter int HIT_TARGET     = 1,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int CNT_W          = 16,
  localparam int IW = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_we_i,
  input  logic [IW-1:0]        cfg_idx_i,
  input  logic                 cfg_en_i,
  input  logic [XLEN-1:0]      cfg_addr_i,
  input  logic [XLEN-1:0]      cfg_data_i,
  input  logic [XLEN-1:0]      cfg_mask_i,
  input  logic                 start_i,
  input  logic                 memwrite_i,
  input  logic [XLEN-1:0]      dataadr_i,
  input  logic [XLEN-1:0]      writedata_i,
  input  logic [1:0]           forwardae_i,
  input  logic [1:0]           forwardbe_i,
  output logic                 armed_o,
  output logic                 pass_o,
  output logic                 fail_o,
  output logic [NUM_WATCH-1:0] hit_vec_o,
  output logic [31:0]          cycle_cnt_o,
  output logic [CNT_W-1:0]     store_cnt_o,
  output logic [CNT_W-1:0]     fwd_a_cnt_o,
  output logic [CNT_W-1:0]     fwd_b_cnt_o
);

  localparam int HW = $clog2(HIT_TARGET + 1);
  localparam logic [HW-1:0] HT = HW'(HIT_TARGET);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [31:0] TLAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE, ARMED, PASS, FAIL
  } state_t;

  state_t state_q, state_d;

  logic [NUM_WATCH-1:0] en_q, en_d;
  logic [XLEN-1:0] addr_q [NUM_WATCH];
  logic [XLEN-1:0] data_q [NUM_WATCH];
  logic [XLEN-1:0] mask_q [NUM_WATCH];
  logic [HW-1:0]   hits_q [NUM_WATCH];
  logic [HW-1:0]   hits_d [NUM_WATCH];

  logic [NUM_WATCH-1:0] match, done, hv_d, hv_q;
  logic [31:0]          cyc_q;
  logic [CNT_W-1:0]     st_q, fa_q, fb_q;
  logic                 cfg_ok, arm, complete, timeout;

  always_comb begin
    cfg_ok = cfg_we_i && (state_q != ARMED)
          && (32'(cfg_idx_i) < 32'(NUM_WATCH));
    en_d = en_q;
    if (cfg_ok) en_d[cfg_idx_i] = cfg_en_i;
    // Arming looks at the enables as they will be after this edge.
    arm = (state_q != ARMED) && start_i && (|en_d);
    for (int i = 0; i < NUM_WATCH; i++) begin
      match[i] = memwrite_i && en_q[i]
              && (dataadr_i == addr_q[i])
              && (((writedata_i ^ data_q[i]) & mask_q[i]) == '0);
      hits_d[i] = hits_q[i];
      if (match[i] && hits_q[i] != HT) hits_d[i] = hits_q[i] + 1'b1;
      hv_d[i] = en_q[i] && (hits_d[i] == HT);
      done[i] = !en_q[i] || (hits_d[i] == HT);
    end
    complete = &done;
    timeout  = (cyc_q == TLAST);
    state_d  = state_q;
    unique case (state_q)
      ARMED: begin
        if (complete)     state_d = PASS;
        else if (timeout) state_d = FAIL;
      end
      default: begin
        if (arm) state_d = ARMED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      en_q    <= '0;
      hv_q    <= '0;
      cyc_q   <= '0;
      st_q    <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
      for (int i = 0; i < NUM_WATCH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        mask_q[i] <= '0;
        hits_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (cfg_ok) begin
        en_q              <= en_d;
        addr_q[cfg_idx_i] <= cfg_addr_i;
        data_q[cfg_idx_i] <= cfg_data_i;
        mask_q[cfg_idx_i] <= cfg_mask_i;
      end
      if (arm) begin
        hv_q  <= '0;
        cyc_q <= '0;
        st_q  <= '0;
        fa_q  <= '0;
        fb_q  <= '0;
        for (int i = 0; i < NUM_WATCH; i++) hits_q[i] <= '0;
      end else if (state_q == ARMED) begin
        cyc_q <= cyc_q + 32'd1;
        hv_q  <= hv_d;
        for (int i = 0; i < NUM_WATCH; i++) hits_q[i] <= hits_d[i];
        if (memwrite_i && st_q != CMAX)
          st_q <= st_q + 1'b1;
        if ((forwardae_i != 2'b00) && fa_q != CMAX)
          fa_q <= fa_q + 1'b1;
        if ((forwardbe_i != 2'b00) && fb_q != CMAX)
          fb_q <= fb_q + 1'b1;
      end
    end
  end

  assign armed_o     = (state_q == ARMED);
  assign pass_o      = (state_q == PASS);
  assign fail_o      = (state_q == FAIL);
  assign hit_vec_o   = hv_q;
  assign cycle_cnt_o = cyc_q;
  assign store_cnt_o = st_q;
  assign fwd_a_cnt_o = fa_q;
  assign fwd_b_cnt_o = fb_q;

endmodule

// File: tb/tb_store_watch_monitor.sv
// Bench for store_watch_monitor: two instances (hit target 1 / 3)
// share stimulus; a queued scoreboard checks each at its due cycle.
module tb_store_watch_monitor;

  localparam int F_ARM = 0, F_PASS = 1, F_FAIL = 2, F_HIT = 3;
  localparam int F_CYC = 4, F_ST = 5, F_FA = 6, F_FB = 7;

  logic        clk = 0;
  logic        reset = 1;
  logic        cfg_we = 0;
  logic [0:0]  cfg_idx = 0;
  logic        cfg_en = 0;
  logic [31:0] cfg_addr = 0, cfg_data = 0, cfg_mask = 0;
  logic        start = 0;
  logic        memwrite = 0;
  logic [31:0] dataadr = 0, writedata = 0;
  logic [1:0]  fwdae = 0, fwdbe = 0;

  logic        a_armed, a_pass, a_fail;
  logic [1:0]  a_hit;
  logic [31:0] a_cyc;
  logic [1:0]  a_st, a_fa, a_fb;
  logic        b_armed, b_pass, b_fail;
  logic [1:0]  b_hit;
  logic [31:0] b_cyc;
  logic [15:0] b_st, b_fa, b_fb;

  store_watch_monitor #(
    .XLEN(32), .NUM_WATCH(2), .HIT_TARGET(1),
    .TIMEOUT_CYCLES(8), .CNT_W(2)
  ) dut_a (
    .clk(clk), .reset(reset),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_en_i(cfg_en),
    .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data), .cfg_mask_i(cfg_mask),
    .start_i(start), .memwrite_i(memwrite), .dataadr_i(dataadr),
    .writedata_i(writedata), .forwardae_i(fwdae), .forwardbe_i(fwdbe),
    .armed_o(a_armed), .pass_o(a_pass), .fail_o(a_fail),
    .hit_vec_o(a_hit), .cycle_cnt_o(a_cyc), .store_cnt_o(a_st),
    .fwd_a_cnt_o(a_fa), .fwd_b_cnt_o(a_fb)
  );

  store_watch_monitor #(
    .XLEN(32), .NUM_WATCH(2), .HIT_TARGET(3),
    .TIMEOUT_CYCLES(20), .CNT_W(16)
  ) dut_b (
    .clk(clk), .reset(reset),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_en_i(cfg_en),
    .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data), .cfg_mask_i(cfg_mask),
    .start_i(start), .memwrite_i(memwrite), .dataadr_i(dataadr),
    .writedata_i(writedata), .forwardae_i(fwdae), .forwardbe_i(fwdbe),
    .armed_o(b_armed), .pass_o(b_pass), .fail_o(b_fail),
    .hit_vec_o(b_hit), .cycle_cnt_o(b_cyc), .store_cnt_o(b_st),
    .fwd_a_cnt_o(b_fa), .fwd_b_cnt_o(b_fb)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          inst;
    int          fld;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get(bit b, int f);
    logic [31:0] v;
    v = '0;
    case (f)
      F_ARM:  v = b ? 32'(b_armed) : 32'(a_armed);
      F_PASS: v = b ? 32'(b_pass)  : 32'(a_pass);
      F_FAIL: v = b ? 32'(b_fail)  : 32'(a_fail);
      F_HIT:  v = b ? 32'(b_hit)   : 32'(a_hit);
      F_CYC:  v = b ? b_cyc        : a_cyc;
      F_ST:   v = b ? 32'(b_st)    : 32'(a_st);
      F_FA:   v = b ? 32'(b_fa)    : 32'(a_fa);
      F_FB:   v = b ? 32'(b_fb)    : 32'(a_fb);
      default: v = 'x;
    endcase
    return v;
  endfunction

  // Monitor: pops every expectation whose cycle has been reached.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] act;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      act = get(e.inst, e.fld);
      n_cmp = n_cmp + 1;
      if (act !== e.exp) begin
        n_bad = n_bad + 1;
        $display("FAIL %s dut_%s: got %0h want %0h",
                 e.nm, e.inst ? "b" : "a", act, e.exp);
      end
    end
  end

  task automatic chk(bit inst, int fld, logic [31:0] e, string nm);
    exp_t x;
    x.due = cyc; x.inst = inst; x.fld = fld; x.exp = e; x.nm = nm;
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic cfg(bit idx, bit en, logic [31:0] a, logic [31:0] d,
                     logic [31:0] m);
    cfg_we = 1; cfg_idx = idx; cfg_en = en;
    cfg_addr = a; cfg_data = d; cfg_mask = m;
    tick();
    cfg_we = 0;
  endtask

  task automatic arm();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic store(logic [31:0] a, logic [31:0] d);
    memwrite = 1; dataadr = a; writedata = d;
    tick();
    memwrite = 0; dataadr = 0; writedata = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and single-hit pass on the 3rd armed cycle
    do_reset();
    for (int k = 0; k < 2; k++) begin
      chk(k[0], F_ARM,  0, "rst_armed");
      chk(k[0], F_PASS, 0, "rst_pass");
      chk(k[0], F_FAIL, 0, "rst_fail");
      chk(k[0], F_HIT,  0, "rst_hit");
      chk(k[0], F_CYC,  0, "rst_cyc");
      chk(k[0], F_ST,   0, "rst_store");
    end
    cfg(0, 1, 32'hA, 32'hA, 32'hFFFF_FFFF);
    arm();
    chk(0, F_ARM, 1, "t1_armed");
    idle(2);
    chk(0, F_PASS, 0, "t1_nopass");
    store(32'hA, 32'hA);
    chk(0, F_PASS, 1, "t1_pass");
    chk(0, F_HIT,  1, "t1_hit");
    chk(0, F_ST,   1, "t1_store");
    chk(0, F_CYC,  3, "t1_cyc");
    idle(2);
    chk(0, F_CYC,  3, "t1_frozen_cyc");
    chk(0, F_PASS, 1, "t1_sticky");

    // Masked compare with HIT_TARGET=3
    do_reset();
    cfg(0, 1, 32'h40, 32'h12, 32'h0000_00FF);
    arm();
    store(32'h40, 32'hAB12);
    store(32'h44, 32'h12);
    store(32'h40, 32'h0012);
    store(32'h40, 32'h13);
    chk(1, F_PASS, 0, "t2_nopass");
    chk(1, F_ST,   4, "t2_store4");
    store(32'h40, 32'h7712);
    chk(1, F_PASS, 1, "t2_pass");
    chk(1, F_HIT,  1, "t2_hit");
    chk(1, F_ST,   5, "t2_store5");
    chk(1, F_CYC,  5, "t2_cyc");

    // Two channels, disable one and re-arm, cfg ignored while armed
    do_reset();
    cfg(0, 1, 32'h10, 32'h1, 32'hFFFF_FFFF);
    cfg(1, 1, 32'h14, 32'h2, 32'hFFFF_FFFF);
    arm();
    store(32'h10, 32'h1);
    chk(0, F_HIT,  1, "t3_hit_ch0");
    chk(0, F_PASS, 0, "t3_nopass");
    store(32'h14, 32'h2);
    chk(0, F_HIT,  3, "t3_hit_both");
    chk(0, F_PASS, 1, "t3_pass");
    cfg(1, 0, 32'h14, 32'h2, 32'hFFFF_FFFF);
    arm();
    chk(0, F_ARM, 1, "t3_rearm");
    chk(0, F_HIT, 0, "t3_hit_clr");
    cfg(1, 1, 32'h14, 32'h2, 32'hFFFF_FFFF);
    store(32'h10, 32'h1);
    chk(0, F_PASS, 1, "t3_pass_ch0");
    chk(0, F_HIT,  1, "t3_hit_ch0only");

    // Timeout after 8 armed edges, then re-arm from FAIL
    do_reset();
    cfg(0, 1, 32'h10, 32'h1, 32'hFFFF_FFFF);
    arm();
    idle(7);
    chk(0, F_FAIL, 0, "t4_nofail7");
    chk(0, F_CYC,  7, "t4_cyc7");
    idle(1);
    chk(0, F_FAIL, 1, "t4_fail");
    chk(0, F_ARM,  0, "t4_disarmed");
    chk(0, F_CYC,  8, "t4_cyc8");
    arm();
    chk(0, F_ARM, 1, "t4_rearm");
    chk(0, F_CYC, 0, "t4_cyc_clr");

    // Match on the timeout edge: pass wins
    do_reset();
    cfg(0, 1, 32'h10, 32'h1, 32'hFFFF_FFFF);
    arm();
    idle(7);
    store(32'h10, 32'h1);
    chk(0, F_PASS, 1, "t4b_pass");
    chk(0, F_FAIL, 0, "t4b_nofail");
    chk(0, F_CYC,  8, "t4b_cyc");

    // Forwarding and store counters saturating at 3 (CNT_W=2)
    do_reset();
    cfg(0, 1, 32'h10, 32'h1, 32'hFFFF_FFFF);
    arm();
    for (int k = 0; k < 5; k++) begin
      memwrite = 1; dataadr = 32'h20; writedata = 32'h1;
      fwdae = (k < 4) ? 2'b10 : 2'b00;
      fwdbe = (k < 2) ? 2'b01 : 2'b00;
      tick();
    end
    memwrite = 0; dataadr = 0; writedata = 0; fwdae = 0; fwdbe = 0;
    chk(0, F_FA,  3, "t5_fwd_a");
    chk(0, F_FB,  2, "t5_fwd_b");
    chk(0, F_ST,  3, "t5_store_sat");
    chk(0, F_CYC, 5, "t5_cyc");
    chk(1, F_ST,  5, "t5_store_wide");
    chk(1, F_FA,  4, "t5_fwd_a_wide");

    // Reset mid-armed clears everything, including configs
    do_reset();
    cfg(0, 1, 32'h10, 32'h1, 32'hFFFF_FFFF);
    cfg(1, 1, 32'h14, 32'h2, 32'hFFFF_FFFF);
    arm();
    store(32'h10, 32'h1);
    chk(0, F_HIT, 1, "t6_half");
    do_reset();
    chk(0, F_ARM, 0, "t6_rst_armed");
    chk(0, F_HIT, 0, "t6_rst_hit");
    chk(0, F_ST,  0, "t6_rst_store");
    chk(0, F_CYC, 0, "t6_rst_cyc");
    arm();
    chk(0, F_ARM, 0, "t6_start_ignored");
    cfg_we = 1; cfg_idx = 0; cfg_en = 1;
    cfg_addr = 32'h10; cfg_data = 32'h1; cfg_mask = 32'hFFFF_FFFF;
    start = 1;
    tick();
    cfg_we = 0; start = 0;
    chk(0, F_ARM, 1, "t6_cfg_start");
    store(32'h10, 32'h1);
    chk(0, F_PASS, 1, "t6_pass_ch0");

    idle(3);
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d pending checks want 0", q.size());
      n_bad = n_bad + q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/store_watch_monitor.md
# store_watch_monitor

Synthesizable, parametrised store-watch and forwarding-statistics monitor for the RV32I pipelined core. It sits beside the core's top level, snoops the data-memory write port (MemWrite, DataAdr, WriteData) and the hazard unit's ForwardAE/ForwardBE selects, and replaces hard-coded single-address end-of-test checks with NUM_WATCH programmable watch channels. It adds hit-count targets, a timeout, and saturating event counters, so pass/fail is decided in hardware on FPGA as well as in simulation.

## Interface
- XLEN, 32, address/data width
- NUM_WATCH, 2, number of watch channels (>=1)
- HIT_TARGET, 1, matching stores required per enabled channel (>=1)
- TIMEOUT_CYCLES, 10000, armed cycles before FAIL (>=1)
- CNT_W, 16, width of statistic counters

- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- cfg_we_i  in  1  write watch entry cfg_idx_i
- cfg_idx_i  in  max(1,$clog2(NUM_WATCH))  channel index
- cfg_en_i  in  1  channel enable
- cfg_addr_i  in  XLEN  watched address
- cfg_data_i  in  XLEN  watched data
- cfg_mask_i  in  XLEN  data compare mask (1 = compare bit)
- start_i  in  1  arm monitor
- memwrite_i  in  1  core store strobe
- dataadr_i  in  XLEN  store address
- writedata_i  in  XLEN  store data
- forwardae_i  in  2  hazard-unit ForwardAE
- forwardbe_i  in  2  hazard-unit ForwardBE
- armed_o  out  1  state == ARMED
- pass_o  out  1  state == PASS
- fail_o  out  1  state == FAIL
- hit_vec_o  out  NUM_WATCH  per-channel done (hits == HIT_TARGET)
- cycle_cnt_o  out  32  armed cycles elapsed
- store_cnt_o  out  CNT_W  stores seen while armed
- fwd_a_cnt_o  out  CNT_W  armed cycles with forwardae_i != 0
- fwd_b_cnt_o  out  CNT_W  armed cycles with forwardbe_i != 0

## Operation
- States: IDLE, ARMED, PASS, FAIL. Reset: IDLE. All counters, hit counters and channel configs cleared (en=0, addr/data/mask=0). All outputs 0.
- Config: cfg_we_i writes {en, addr, data, mask} into channel cfg_idx_i in IDLE, PASS or FAIL. It is ignored in ARMED. An out-of-range index is ignored.
- IDLE/PASS/FAIL -> ARMED on start_i, if at least one channel is enabled (including a config write in the same cycle). Otherwise start_i is ignored. Entering ARMED clears cycle_cnt, store_cnt, fwd counters and all hit counters.
- Channel match in ARMED: memwrite_i && en && dataadr_i == addr && (writedata_i & mask) == (data & mask). One store may match several channels; each matching channel increments.
- Hit counter per channel: saturates at HIT_TARGET. hit_vec_o[i] = (hits[i] == HIT_TARGET). Disabled channels read 0 and are excluded from completion.
- Completion: all enabled channels done after this edge's updates -> PASS.
- Timeout: in ARMED, if cycle_cnt == TIMEOUT_CYCLES-1 at an edge and completion is not reached -> FAIL.
- Simultaneous completion and timeout: PASS wins.
- store_cnt increments on each memwrite_i in ARMED. fwd_a_cnt/fwd_b_cnt increment independently per armed cycle with a nonzero select. All three saturate at 2^CNT_W-1. cycle_cnt increments every armed edge.
- PASS/FAIL: sticky. Counters and hit_vec frozen and readable. Leaves only via reset or start_i (re-arm).
- Reset mid-ARMED: back to IDLE next edge with everything cleared, including configs.

## Timing
- All outputs registered. No combinational input-to-output path.
- A store presented in the cycle before edge N is sampled at edge N. Hit/store counters reflect it immediately after N. pass_o rises after N if it completes the set (1-cycle latency).
- armed_o rises after the edge sampling start_i. The first armed sampling edge is the next one.
- fail_o rises after exactly TIMEOUT_CYCLES sampling edges in ARMED. cycle_cnt_o then reads TIMEOUT_CYCLES.
- start_i while ARMED is ignored (no restart).

## Test plan
- Ch0 {en, 0xA, 0xA, 0xFFFFFFFF}, start, store (0xA, 0xA) on the 3rd armed cycle -> pass_o=1 one edge later, hit_vec_o=01, store_cnt_o=1, cycle_cnt_o=3.
- HIT_TARGET=3, ch0 addr 0x40, mask 0x000000FF, data 0x12. Stores (0x40, 0xAB12), (0x44, 0x12), (0x40, 0x0012), (0x40, 0x13), (0x40, 0x7712) -> PASS only after the 5th store, store_cnt_o=5.
- Two channels, ch0 (0x10, 1), ch1 (0x14, 2). Store only ch0 -> hit_vec_o=01, no PASS. Then ch1 -> PASS. Then ch1 disabled and re-armed: single ch0 store -> PASS.
- TIMEOUT_CYCLES=8, no matching store -> fail_o=1 after the 8th armed edge, cycle_cnt_o=8. Variant: matching store sampled on the 8th edge -> pass_o=1, fail_o=0.
- Drive forwardae_i=10 for 4 armed cycles and forwardbe_i=01 for 2, with CNT_W=2 and 5 stores -> fwd_a_cnt_o=3 (saturated), fwd_b_cnt_o=2, store_cnt_o=3.
- Reset asserted mid-ARMED after 1 of 2 hits -> all outputs 0 next edge. start_i afterwards is ignored (no channel enabled), and a cfg write is accepted in IDLE.
